// File: rtl/mutex_value_client.sv
// Client for one write/read port pair of the shared mutex-value arbiter: keeps a shadow of the
// shared value and performs set/add/wrap-aware-max as echo-confirmed writes. Macro: MUTEX_CLIENT_TIMEOUT_EN.
module mutex_value_client #(
  parameter int WIDTH     = 32,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic             core_clk,
  input  logic             core_rst_n,
  input  logic             upd_valid_i,
  output logic             upd_ready_o,
  input  logic [1:0]       upd_op_i,
  input  logic [WIDTH-1:0] upd_value_i,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] shadow_o,
  output logic             changed_o,
  input  logic             mv_valid_i,
  output logic             mv_ready_o,
  input  logic [WIDTH-1:0] mv_value_i,
  output logic             mv_valid_o,
  input  logic             mv_ready_i,
  output logic [WIDTH-1:0] mv_value_o
);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MAX  = 2'b10;
  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_NOOP = 2'b01;
  localparam logic [1:0] ST_LOST = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_SEND = 3'd2,
    S_ECHO = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // a is strictly ahead of b in modulo-2^WIDTH sequence space
  function automatic logic newer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    d = a - b;
    return (d != {WIDTH{1'b0}}) && !d[WIDTH-1];
  endfunction

  state_t           state_r, state_s;
  logic [1:0]       op_r, op_s;
  logic [WIDTH-1:0] opnd_r, opnd_s;
  logic [WIDTH-1:0] n_r, n_s;
  logic [RW-1:0]    retry_r, retry_s;
  logic [1:0]       status_r, status_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [WIDTH-1:0] shadow_r;
  logic             changed_r, done_r, upd_ready_r, mv_ready_r, mv_valid_r;
  logic             bcast_s;

`ifdef MUTEX_CLIENT_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [1:0] ST_TMO = 2'b11;
  logic [TW-1:0] cnt_r, cnt_s;
`endif

  assign bcast_s = mv_valid_i && mv_ready_r;

  // Next-state and transaction datapath
  always_comb begin
    state_s  = state_r;
    op_s     = op_r;
    opnd_s   = opnd_r;
    n_s      = n_r;
    retry_s  = retry_r;
    status_s = status_r;
    result_s = result_r;
`ifdef MUTEX_CLIENT_TIMEOUT_EN
    cnt_s    = cnt_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (upd_valid_i && upd_ready_r) begin
          op_s    = upd_op_i;
          opnd_s  = upd_value_i;
          retry_s = {RW{1'b0}};
          state_s = S_CALC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CALC: begin
        // a broadcast landing now makes the shadow stale, so recompute next cycle
        if (bcast_s) begin
          state_s = S_CALC;
        end else begin
          state_s = S_SEND;
          case (op_r)
            OP_ADD: n_s = shadow_r + opnd_r;
            OP_MAX: begin
              if (newer(opnd_r, shadow_r)) begin
                n_s = opnd_r;
              end else begin
                status_s = ST_NOOP;
                result_s = shadow_r;
                state_s  = S_DONE;
              end
            end
            default: n_s = opnd_r;
          endcase
        end
      end
      S_SEND: begin
        if (mv_ready_i) begin
          state_s = S_ECHO;
`ifdef MUTEX_CLIENT_TIMEOUT_EN
          cnt_s   = {TW{1'b0}};
`endif
        end else begin
          state_s = S_SEND;
        end
      end
      S_ECHO: begin
        if (bcast_s) begin
          result_s = n_r;
          if (mv_value_i == n_r) begin
            status_s = ST_OK;
            state_s  = S_DONE;
          end else if ((op_r == OP_MAX) && newer(n_r, mv_value_i) && (retry_r < RW'(MAX_RETRY))) begin
            retry_s = retry_r + {{(RW-1){1'b0}}, 1'b1};
            state_s = S_CALC;
          end else begin
            status_s = ST_LOST;
            state_s  = S_DONE;
          end
`ifdef MUTEX_CLIENT_TIMEOUT_EN
        end else if (cnt_r == TW'(TIMEOUT - 1)) begin
          status_s = ST_TMO;
          result_s = n_r;
          state_s  = S_DONE;
        end else begin
          cnt_s   = cnt_r + {{(TW-1){1'b0}}, 1'b1};
          state_s = S_ECHO;
`else
        end else begin
          state_s = S_ECHO;
`endif
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, shadow and registered outputs
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_r     <= S_IDLE;
      op_r        <= 2'b00;
      opnd_r      <= {WIDTH{1'b0}};
      n_r         <= {WIDTH{1'b0}};
      retry_r     <= {RW{1'b0}};
      status_r    <= 2'b00;
      result_r    <= {WIDTH{1'b0}};
      shadow_r    <= {WIDTH{1'b0}};
      changed_r   <= 1'b0;
      done_r      <= 1'b0;
      upd_ready_r <= 1'b0;
      mv_ready_r  <= 1'b0;
      mv_valid_r  <= 1'b0;
`ifdef MUTEX_CLIENT_TIMEOUT_EN
      cnt_r       <= {TW{1'b0}};
`endif
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      opnd_r      <= opnd_s;
      n_r         <= n_s;
      retry_r     <= retry_s;
      status_r    <= status_s;
      result_r    <= result_s;
      shadow_r    <= bcast_s ? mv_value_i : shadow_r;
      changed_r   <= bcast_s;
      done_r      <= (state_s == S_DONE);
      upd_ready_r <= (state_s == S_IDLE);
      mv_ready_r  <= 1'b1;
      mv_valid_r  <= (state_s == S_SEND);
`ifdef MUTEX_CLIENT_TIMEOUT_EN
      cnt_r       <= cnt_s;
`endif
    end
  end

  assign upd_ready_o = upd_ready_r;
  assign done_o      = done_r;
  assign status_o    = status_r;
  assign result_o    = result_r;
  assign shadow_o    = shadow_r;
  assign changed_o   = changed_r;
  assign mv_ready_o  = mv_ready_r;
  assign mv_valid_o  = mv_valid_r;
  assign mv_value_o  = n_r;
endmodule

// File: tb/tb_mutex_value_client.sv
// Randomized self-checking bench for mutex_value_client against a transaction-level model.
module tb_mutex_value_client;
  logic        core_clk = 1'b0;
  logic        core_rst_n = 1'b0;
  logic        upd_valid_i = 1'b0;
  logic        upd_ready_o;
  logic [1:0]  upd_op_i = 2'b00;
  logic [31:0] upd_value_i = 32'h0;
  logic        done_o;
  logic [1:0]  status_o;
  logic [31:0] result_o, shadow_o, mv_value_o;
  logic        changed_o, mv_ready_o, mv_valid_o;
  logic        mv_valid_i = 1'b0;
  logic [31:0] mv_value_i = 32'h0;
  logic        mv_ready_i = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_shadow = 32'h0;
  localparam int MAXR = 3;

  mutex_value_client #(.WIDTH(32), .MAX_RETRY(MAXR), .TIMEOUT(8)) dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o), .upd_op_i(upd_op_i), .upd_value_i(upd_value_i),
    .done_o(done_o), .status_o(status_o), .result_o(result_o), .shadow_o(shadow_o), .changed_o(changed_o),
    .mv_valid_i(mv_valid_i), .mv_ready_o(mv_ready_o), .mv_value_i(mv_value_i),
    .mv_valid_o(mv_valid_o), .mv_ready_i(mv_ready_i), .mv_value_o(mv_value_o)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  function automatic bit m_newer(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return (d != 32'h0) && (d < 32'h8000_0000);
  endfunction

  // What a single CALC pass should produce from shadow s and operand r
  task automatic model_calc(input logic [1:0] op, input logic [31:0] r, input logic [31:0] s,
                            output bit noop, output logic [31:0] n);
    noop = 1'b0;
    case (op)
      2'b01: n = s + r;
      2'b10: if (m_newer(r, s)) n = r; else begin noop = 1'b1; n = s; end
      default: n = r;
    endcase
  endtask

  task automatic bcast(input logic [31:0] v);
    mv_valid_i = 1'b1; mv_value_i = v;
    step();
    mv_valid_i = 1'b0;
    m_shadow = v;
    check("shadow", shadow_o, v);
    check("changed_pulse", {31'h0, changed_o}, 32'h1);
    step();
    check("changed_drop", {31'h0, changed_o}, 32'h0);
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [31:0] r, input bit coll,
                         input logic [31:0] coll_v, input logic [31:0] echo_off, input bit ins_send);
    logic [31:0] n, e;
    bit noop;
    int retry = 0;
    check("upd_ready_idle", {31'h0, upd_ready_o}, 32'h1);
    upd_valid_i = 1'b1; upd_op_i = op; upd_value_i = r;
    step();
    upd_valid_i = 1'b0; upd_value_i = $urandom;
    for (int k = 0; k < 8; k++) begin
      if (coll && k == 0) begin
        mv_valid_i = 1'b1; mv_value_i = coll_v;
        step();
        mv_valid_i = 1'b0;
        m_shadow = coll_v;
        check("calc_repeat_no_valid", {31'h0, mv_valid_o}, 32'h0);
      end
      model_calc(op, r, m_shadow, noop, n);
      step();
      if (noop) begin
        check("noop_done", {31'h0, done_o}, 32'h1);
        check("noop_status", {30'h0, status_o}, 32'h1);
        check("noop_result", result_o, m_shadow);
        check("noop_no_write", {31'h0, mv_valid_o}, 32'h0);
        break;
      end
      check("send_valid", {31'h0, mv_valid_o}, 32'h1);
      check("send_value", mv_value_o, n);
      for (int d = $urandom_range(0, 2); d > 0; d--) begin
        step();
        check("send_hold", {31'h0, mv_valid_o}, 32'h1);
        check("send_hold_value", mv_value_o, n);
      end
      mv_ready_i = 1'b1;
      if (ins_send) begin
        mv_valid_i = 1'b1; mv_value_i = n ^ 32'h1;
        m_shadow = n ^ 32'h1;
      end
      step();
      mv_ready_i = 1'b0; mv_valid_i = 1'b0;
      check("accept_drop", {31'h0, mv_valid_o}, 32'h0);
      check("shadow_in_send", shadow_o, m_shadow);
      e = n - echo_off;
      for (int d = $urandom_range(0, 2); d > 0; d--) begin
        step();
        check("echo_wait_no_done", {31'h0, done_o}, 32'h0);
      end
      mv_valid_i = 1'b1; mv_value_i = e;
      step();
      mv_valid_i = 1'b0;
      m_shadow = e;
      check("echo_shadow", shadow_o, e);
      if (e == n) begin
        check("ok_done", {31'h0, done_o}, 32'h1);
        check("ok_status", {30'h0, status_o}, 32'h0);
        check("ok_result", result_o, n);
        break;
      end else if (op == 2'b10 && m_newer(n, e) && retry < MAXR) begin
        retry++;
        check("retry_no_done", {31'h0, done_o}, 32'h0);
      end else begin
        check("lost_done", {31'h0, done_o}, 32'h1);
        check("lost_status", {30'h0, status_o}, 32'h2);
        check("lost_result", result_o, n);
        break;
      end
    end
    step();
    check("done_pulse_end", {31'h0, done_o}, 32'h0);
    check("upd_ready_back", {31'h0, upd_ready_o}, 32'h1);
  endtask

  initial begin
    logic [1:0] op;
    logic [31:0] s, r, off;
    step();
    check("rst_upd_ready", {31'h0, upd_ready_o}, 32'h0);
    check("rst_mv_ready", {31'h0, mv_ready_o}, 32'h0);
    check("rst_done", {31'h0, done_o}, 32'h0);
    check("rst_status", {30'h0, status_o}, 32'h0);
    check("rst_result", result_o, 32'h0);
    check("rst_shadow", shadow_o, 32'h0);
    check("rst_mv_valid", {31'h0, mv_valid_o}, 32'h0);
    check("rst_changed", {31'h0, changed_o}, 32'h0);
    core_rst_n = 1'b1;
    step();
    check("mv_ready_after_rst", {31'h0, mv_ready_o}, 32'h1);

    // Directed cases from the intended use
    bcast(32'h0000_0010);
    run_txn(2'b01, 32'h5, 1'b0, 32'h0, 32'h0, 1'b0);
    bcast(32'hFFFF_FFF0);
    run_txn(2'b10, 32'h0000_0004, 1'b0, 32'h0, 32'h0, 1'b0);
    run_txn(2'b10, 32'hFFFF_FF00, 1'b0, 32'h0, 32'h0, 1'b0);
    bcast(32'h0000_0010);
    run_txn(2'b10, 32'h20, 1'b0, 32'h0, 32'h8, 1'b0);
    bcast(32'h0000_0010);
    run_txn(2'b10, 32'h20, 1'b0, 32'h0, 32'hFFFF_FFF0, 1'b0);
    bcast(32'h0000_0030);
    run_txn(2'b01, 32'h1, 1'b1, 32'h40, 32'h0, 1'b0);
    run_txn(2'b11, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 1'b1);

`ifdef MUTEX_CLIENT_TIMEOUT_EN
    begin
      int cyc = 0;
      upd_valid_i = 1'b1; upd_op_i = 2'b00; upd_value_i = 32'hABCD;
      step();
      upd_valid_i = 1'b0;
      step();
      step();
      mv_ready_i = 1'b1;
      step();
      mv_ready_i = 1'b0;
      while (!done_o && cyc < 20) begin
        step();
        cyc++;
      end
      check("tmo_cycles", cyc, 32'd8);
      check("tmo_status", {30'h0, status_o}, 32'h3);
      check("tmo_result", result_o, 32'hABCD);
      step();
    end
`endif

    // Reset in mid-transaction aborts without a completion pulse
    upd_valid_i = 1'b1; upd_op_i = 2'b00; upd_value_i = 32'h55;
    step();
    upd_valid_i = 1'b0;
    step();
    check("mid_send_valid", {31'h0, mv_valid_o}, 32'h1);
    core_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, mv_valid_o}, 32'h0);
    check("mid_rst_shadow", shadow_o, 32'h0);
    step();
    check("mid_rst_no_done", {31'h0, done_o}, 32'h0);
    core_rst_n = 1'b1;
    m_shadow = 32'h0;
    step();

    for (int i = 0; i < 40; i++) begin
      s = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      bcast(s);
      op = 2'($urandom_range(0, 3));
      if (op == 2'b10)
        r = ($urandom_range(0, 1) == 1) ? (s + 32'($urandom_range(0, 64))) : (s - 32'($urandom_range(0, 64)));
      else
        r = $urandom;
      case ($urandom_range(0, 3))
        0, 1:    off = 32'h0;
        2:       off = 32'($urandom_range(1, 16));
        default: off = 32'h0 - 32'($urandom_range(1, 16));
      endcase
      run_txn(op, r, ($urandom_range(0, 3) == 0), $urandom, off, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
